// File: rtl/accumulator_requantize.sv
// accumulator_requantize: narrows packed 2W-bit dot-product accumulators to
// packed W-bit fixed-point values using one shared round/saturate unit.
// The unit handles one element per cycle. Both sides use a valid/ready handshake.
// Optional feature: define RELU_EN to clamp negative results to zero (fused ReLU).
module accumulator_requantize #(
  parameter int W     = 16,
  parameter int D     = 8,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*D*W-1:0] packed_in,
  input  logic             in_v,
  output logic             in_ready,
  output logic [D*W-1:0]   packed_out,
  output logic             out_v,
  input  logic             out_ready
);

  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;

  // Internal arithmetic is one bit wider than the accumulator, so adding the
  // rounding constant can never wrap.
  localparam logic signed [2*W:0] ROUND_C = {{(2*W){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [2*W:0] MAX_C   = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_C   = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*D*W-1:0]      hold_q;
  logic [2*W-1:0]        elem_x;
  logic signed [2*W:0]   elem_r;
  logic signed [2*W:0]   elem_q;
  logic [W-1:0]          elem_y;

  // Next-state logic: accept in IDLE, walk D elements in PROC, wait for the consumer in DONE.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (in_v && in_ready) state_n = PROC;
      PROC: if (cnt_q == CNT_W'(D - 1)) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign out_v = (state_q == DONE);

  // Select the captured accumulator for the current element. Element 0 is in the MSBs.
  always_comb begin
    elem_x = '0;
    for (int i = 0; i < D; i++) begin
      if (cnt_q == CNT_W'(i)) elem_x = hold_q[(D-1-i)*2*W +: 2*W];
    end
  end

  // Shared unit: round half up, arithmetic shift, clamp to two's-complement W-bit limits.
  always_comb begin
    elem_r = $signed({elem_x[2*W-1], elem_x}) + ROUND_C;
    elem_q = elem_r >>> SHIFT;
    if (elem_q > MAX_C)      elem_y = MAX_C[W-1:0];
    else if (elem_q < MIN_C) elem_y = MIN_C[W-1:0];
    else                     elem_y = elem_q[W-1:0];
`ifdef RELU_EN
    if (elem_y[W-1]) elem_y = '0;
`endif
  end

  // State, counter, holding register and result slices. in_ready stays low through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      packed_out <= '0;
      in_ready   <= 1'b0;
    end else begin
      state_q  <= state_n;
      in_ready <= (state_n == IDLE);
      case (state_q)
        IDLE: begin
          if (in_v && in_ready) begin
            hold_q <= packed_in;
            cnt_q  <= '0;
          end
        end
        PROC: begin
          for (int i = 0; i < D; i++) begin
            if (cnt_q == CNT_W'(i)) packed_out[(D-1-i)*W +: W] <= elem_y;
          end
          if (cnt_q == CNT_W'(D - 1)) cnt_q <= '0;
          else                        cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_requantize.sv
// tb_accumulator_requantize: randomized and directed rows checked against an
// arithmetic reference model of the requantizer (honours RELU_EN too).
module tb_accumulator_requantize;

  localparam int W     = 16;
  localparam int D     = 8;
  localparam int SHIFT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [2*D*W-1:0] packed_in;
  logic             in_v;
  logic             in_ready;
  logic [D*W-1:0]   packed_out;
  logic             out_v;
  logic             out_ready;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [D*W-1:0] prev_out;

  accumulator_requantize #(.W(W), .D(D), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .packed_in(packed_in), .in_v(in_v), .in_ready(in_ready),
    .packed_out(packed_out), .out_v(out_v), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: floor((x + 2^(SHIFT-1)) / 2^SHIFT), clamped to the W-bit signed range.
  function automatic logic [W-1:0] ref_elem(input logic [2*W-1:0] x_bits);
    longint x, num, den, q, hi, lo;
    x   = longint'($signed(x_bits));
    den = longint'(1) << SHIFT;
    num = x + (longint'(1) << (SHIFT - 1));
    if (num >= 0) q = num / den;
    else          q = -((-num + den - 1) / den);
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
`ifdef RELU_EN
    if (q < 0) q = 0;
`endif
    return q[W-1:0];
  endfunction

  // Expected packed_out once the first k elements of row are written over prev.
  function automatic logic [D*W-1:0] expect_row(input logic [2*D*W-1:0] row,
                                                input logic [D*W-1:0] prev, input int k);
    logic [D*W-1:0]   res;
    logic [2*D*W-1:0] t;
    logic [D*W-1:0]   p;
    logic [W-1:0]     e;
    res = '0;
    for (int i = 0; i < D; i++) begin
      if (i < k) begin
        t = row >> ((D - 1 - i) * 2 * W);
        e = ref_elem(t[2*W-1:0]);
      end else begin
        p = prev >> ((D - 1 - i) * W);
        e = p[W-1:0];
      end
      res = {res[D*W-W-1:0], e};
    end
    return res;
  endfunction

  function automatic logic [2*D*W-1:0] rand_row();
    logic [2*D*W-1:0] r;
    logic [2*W-1:0]   e;
    r = '0;
    for (int i = 0; i < D; i++) begin
      case ($urandom_range(0, 3))
        0: e = $urandom();
        1: e = 32'($signed(24'($urandom())));
        2: e = {$urandom_range(0, 1) ? 24'hFFFFFF : 24'h000000, 8'h80} + ($urandom_range(0, 255) << 8);
        default: e = 32'($signed(12'($urandom())));
      endcase
      r = {r[2*D*W-2*W-1:0], e};
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [D*W-1:0] obs, input logic [D*W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Send one row, check every partial write, latency, the held result under
  // backpressure, and the output handshake.
  task automatic applyStimulus(input logic [2*D*W-1:0] row, input int hold_cycles);
    int waited;
    int lat;
    logic [D*W-1:0] exp_full;
    waited    = 0;
    in_v      = 1'b1;
    packed_in = row;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("in_ready_wait", D*W'(in_ready), D*W'(1));
    if (in_ready !== 1'b1) begin
      in_v = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_v      = 1'b0;
    packed_in = rand_row();
    exp_full  = expect_row(row, prev_out, D);
    lat = 0;
    for (int k = 1; k <= D + 4; k++) begin
      @(posedge clk); #1;
      if (k < D) checkOutput("partial", packed_out, expect_row(row, prev_out, k));
      if (out_v === 1'b1) begin
        lat = k;
        break;
      end
    end
    // out_v is seen D edges after the accept edge (edge D+1 counting the accept edge).
    checkOutput("latency", D*W'(lat), D*W'(D));
    checkOutput("row", packed_out, exp_full);
    checkOutput("in_ready_busy", D*W'(in_ready), '0);
    for (int c = 0; c < hold_cycles; c++) begin
      in_v      = 1'b1;
      packed_in = rand_row();
      @(posedge clk); #1;
      checkOutput("hold_out_v", D*W'(out_v), D*W'(1));
      checkOutput("hold_data", packed_out, exp_full);
      checkOutput("hold_in_ready", D*W'(in_ready), '0);
    end
    in_v      = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_v_drop", D*W'(out_v), '0);
    checkOutput("in_ready_back", D*W'(in_ready), D*W'(1));
    prev_out = exp_full;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2*D*W-1:0] row;
    prev_out  = '0;
    rst       = 1'b0;
    in_v      = 1'b1;
    out_ready = 1'b0;
    packed_in = rand_row();

    // Reset held with in_v asserted.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_v", D*W'(out_v), '0);
    checkOutput("reset_data", packed_out, '0);
    checkOutput("reset_in_ready", D*W'(in_ready), '0);
    in_v = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", D*W'(in_ready), D*W'(1));

    // Rounding.
    applyStimulus({D{32'h00000180}}, 0);
    checkOutput("round_1p5", packed_out, {D{16'h0002}});
    applyStimulus({32'h00000100, 32'hFFFFFE80, 32'h00000180, 32'h00000080,
                   32'hFFFFFF80, 32'h0000007F, 32'hFFFFFF7F, 32'h00000000}, 1);

    // Saturation.
    applyStimulus({32'h7FFFFFFF, 32'h80000000, 32'h00800000, 32'hFF800000,
                   32'h007FFF7F, 32'h007FFF80, 32'hFF7FFF80, 32'hFF7FFF7F}, 0);

    // Ordering with long backpressure.
    row = '0;
    for (int k = 0; k < D; k++) row = {row[2*D*W-2*W-1:0], 32'(k << 8)};
    applyStimulus(row, 20);
    checkOutput("order", packed_out, {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7});
    repeat (D + 2) @(posedge clk);
    #1;
    checkOutput("not_queued", D*W'(out_v), '0);

    // Reset in the middle of a row.
    row       = rand_row();
    in_v      = 1'b1;
    packed_in = row;
    @(posedge clk); #1;
    in_v = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_partial", packed_out, expect_row(row, prev_out, 4));
    rst = 1'b0;
    #1;
    checkOutput("abort_out_v", D*W'(out_v), '0);
    checkOutput("abort_data", packed_out, '0);
    checkOutput("abort_in_ready", D*W'(in_ready), '0);
    @(posedge clk); #1;
    rst      = 1'b1;
    prev_out = '0;
    @(posedge clk); #1;
    applyStimulus(rand_row(), 2);

    // Random rows with random backpressure.
    for (int n = 0; n < 16; n++) applyStimulus(rand_row(), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
